// File: rtl/mem_stage_sram.sv
// rtl/mem_stage_sram.sv - pipeline memory stage driving a fixed-latency single-port SRAM
module mem_stage_sram #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WAIT_CYCLES = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_EN,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [31:0]       ALU_Res,
  input  logic [31:0]       Val_Rm,
  input  logic [3:0]        Dest,
  output logic              WB_EN_out,
  output logic              MEM_R_EN_out,
  output logic [31:0]       ALU_Res_out,
  output logic [31:0]       MEM_Result,
  output logic [3:0]        Dest_out,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic              sram_we,
  output logic              sram_re,
  input  logic [31:0]       sram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  counter;
  logic        req;
  logic        last;
  logic [31:0] offset;

  assign req    = MEM_R_EN | MEM_W_EN;
  assign last   = (counter == 4'(WAIT_CYCLES - 1));
  assign offset = ALU_Res - 32'(BASE_ADDR);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // DONE never samples a request; the next instruction is seen in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = ACCESS;
      ACCESS:  if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    case (state)
      IDLE:    ready = ~req;
      ACCESS:  ready = 1'b0;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter    <= '0;
      MEM_Result <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we    <= 1'b0;
      sram_re    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          sram_addr  <= ADDR_W'(offset >> 2);
          sram_wdata <= Val_Rm;
          sram_re    <= MEM_R_EN;
          sram_we    <= MEM_W_EN & ~MEM_R_EN;
          counter    <= '0;
        end
        ACCESS: begin
          counter <= counter + 4'd1;
          if (last) begin
            if (sram_re) MEM_Result <= sram_rdata;
            sram_re <= 1'b0;
            sram_we <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Bubbles into MEM/WB while frozen, since that register has no enable.
  assign WB_EN_out    = WB_EN & ready;
  assign MEM_R_EN_out = MEM_R_EN & ready;
  assign ALU_Res_out  = ALU_Res;
  assign Dest_out     = Dest;

endmodule

// File: doc/mem_stage_sram.md
Name: mem_stage_sram

Overview:
- Memory-access stage of the 5-stage pipeline. Sits between the EXE/MEM pipeline register and the MEM/WB pipeline register.
- Performs LDR/STR word accesses to an external single-port SRAM that has a fixed multi-cycle latency.
- Drives a `ready` signal that freezes the upstream pipeline while an access is in flight.
- Supplies `MEM_Result`, `ALU_Res`, `Dest` and a gated `WB_EN` to the MEM/WB register.

Parameters:
- BASE_ADDR, 1024, byte address that maps to SRAM word 0.
- ADDR_W, 16, SRAM word-address width.
- WAIT_CYCLES, 5, SRAM access latency in cycles; legal range 1..15.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous active-high reset.
- WB_EN  in  1  write-back enable from EXE/MEM.
- MEM_R_EN  in  1  load request.
- MEM_W_EN  in  1  store request.
- ALU_Res  in  32  effective byte address, or ALU result for non-memory ops.
- Val_Rm  in  32  store data.
- Dest  in  4  destination register index.
- WB_EN_out  out  1  WB_EN & ready.
- MEM_R_EN_out  out  1  MEM_R_EN & ready.
- ALU_Res_out  out  32  ALU_Res passed through combinationally.
- MEM_Result  out  32  registered load data.
- Dest_out  out  4  Dest passed through combinationally.
- ready  out  1  1 = stage complete, pipeline may advance; 0 = freeze all upstream pipeline registers and the PC.
- sram_addr  out  ADDR_W  registered word address.
- sram_wdata  out  32  registered store data.
- sram_we  out  1  registered write strobe, active-high.
- sram_re  out  1  registered read strobe, active-high.
- sram_rdata  in  32  SRAM read data, valid in the final ACCESS cycle.

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high.
- On rst at a clk edge:
  - state=IDLE, counter=0.
  - MEM_Result=0, sram_addr=0, sram_wdata=0, sram_we=0, sram_re=0.
  - Combinational outputs follow their inputs; with state IDLE, ready=1 when no request is present.
- Request = MEM_R_EN | MEM_W_EN. If both are asserted, the read wins and the write is suppressed (sram_we stays 0).
- Address mapping: word = (ALU_Res - BASE_ADDR) >> 2, truncated to ADDR_W bits. The low two bits are dropped. No range check.
- FSM has three states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: ready=1, stay in IDLE. Non-memory ops therefore add zero latency.
  - Request: ready=0. At the edge, load sram_addr and sram_wdata (=Val_Rm), assert sram_re or sram_we, clear counter, go to ACCESS.
- ACCESS:
  - ready=0. The strobe is held and counter increments each cycle.
  - In the cycle where counter==WAIT_CYCLES-1, at the edge:
    - for a read, capture sram_rdata into MEM_Result;
    - deassert sram_re and sram_we;
    - go to DONE.
  - A write leaves MEM_Result unchanged.
- DONE:
  - ready=1 for exactly one cycle, so the upstream pipeline advances at this edge.
  - Next state is IDLE unconditionally. Inputs are not sampled as a new request in DONE.
- Total latency of a memory op: 1 (IDLE) + WAIT_CYCLES (ACCESS) + 1 (DONE) cycles. ready is low for WAIT_CYCLES+1 consecutive cycles.
- Inputs are held stable by the freeze while ready=0; the stage does not re-latch them in ACCESS.
- WB_EN_out and MEM_R_EN_out are forced to 0 whenever ready=0. This inserts bubbles into the MEM/WB register, which has no enable.
- Back-to-back memory ops: DONE -> IDLE sees the next instruction, and a new access starts with no extra idle cycle.
- Reset mid-ACCESS: the SRAM strobe drops at that edge, the FSM returns to IDLE and the pending result is discarded.

Test Plan:
- Reset then ALU op (WB_EN=1, MEM_R_EN=MEM_W_EN=0, ALU_Res=0x55, Dest=3) -> ready=1 continuously, WB_EN_out=1, ALU_Res_out=0x55, Dest_out=3, sram_re=sram_we=0.
- STR with ALU_Res=1032 and Val_Rm=0xDEADBEEF, WAIT_CYCLES=5:
  - sram_addr=2, sram_wdata=0xDEADBEEF, sram_we=1 for exactly 5 cycles;
  - ready low for 6 cycles, then high for 1;
  - WB_EN_out=0 throughout.
- LDR from 1032 with sram_rdata=0xDEADBEEF in the final ACCESS cycle -> MEM_Result=0xDEADBEEF in the DONE cycle with ready=1, WB_EN_out=1, MEM_R_EN_out=1.
- STR immediately followed by LDR at the same address -> second access starts on the cycle after DONE; load returns the stored value; ready pattern is 6 low, 1 high, 6 low, 1 high.
- MEM_R_EN=MEM_W_EN=1 together -> only sram_re pulses; sram_we stays 0.
- rst asserted during the 3rd ACCESS cycle of a load -> next cycle state=IDLE, sram_re=0, MEM_Result=0, ready=1 when no request is present.
